// File: rtl/thermocouple_spi_responder.sv
// Thermocouple converter SPI responder: snapshots temperature/fault inputs into a 32-bit frame.
// Optional THERMO_SYNC_EN adds 2-flop synchronizers on cs_n and sclk.
module thermocouple_spi_responder #(
    parameter int CONV_CYCLES = 200,
    parameter int CBITS       = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs_n,
    input  logic        sclk,
    output logic        miso,
    input  logic [13:0] tc_temp,
    input  logic [11:0] junction_temp,
    input  logic        fault_scv,
    input  logic        fault_scg,
    input  logic        fault_oc,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {IDLE, CONVERT, READY, SHIFT} state_t;

    localparam logic [CBITS-1:0] CONV_LAST = CBITS'(CONV_CYCLES - 1);

    state_t             state;
    logic               cs_in;
    logic               sclk_in;
    logic               cs_q;
    logic               sclk_q;
    logic               sclk_qq;
    logic               sclk_fall;
    logic               drained;
    logic [4:0]         bit_cnt;
    logic [CBITS-1:0]   conv_cnt;
    logic [31:0]        frame;
    logic [31:0]        shreg;
    logic [31:0]        live_frame;

`ifdef THERMO_SYNC_EN
    logic [1:0] cs_sync;
    logic [1:0] sclk_sync;

    // Two-flop synchronizers for the asynchronous SPI pins
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync   <= 2'b11;
            sclk_sync <= 2'b00;
        end else begin
            cs_sync   <= {cs_sync[0], cs_n};
            sclk_sync <= {sclk_sync[0], sclk};
        end
    end

    assign cs_in   = cs_sync[1];
    assign sclk_in = sclk_sync[1];
`else
    assign cs_in   = cs_n;
    assign sclk_in = sclk;
`endif

    assign live_frame = {tc_temp, 1'b0,
                         fault_scv | fault_scg | fault_oc,
                         junction_temp, 1'b0,
                         fault_scv, fault_scg, fault_oc};

    assign sclk_fall = sclk_qq & ~sclk_q;

    // Sampling registers for cs_n and sclk, plus sclk history for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            sclk_qq <= 1'b0;
        end else begin
            cs_q    <= cs_in;
            sclk_q  <= sclk_in;
            sclk_qq <= sclk_q;
        end
    end

    // Conversion / shift state machine with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            miso       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame      <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            conv_cnt   <= '0;
            drained    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    state    <= CONVERT;
                    conv_cnt <= '0;
                    busy     <= 1'b1;
                end
                CONVERT: begin
                    if (!cs_q) begin
                        busy    <= 1'b0;
                        state   <= SHIFT;
                        shreg   <= frame;
                        miso    <= frame[31];
                        bit_cnt <= 5'd31;
                        drained <= 1'b0;
                    end else if (conv_cnt < CONV_LAST) begin
                        conv_cnt <= conv_cnt + 1'b1;
                    end else begin
                        frame <= live_frame;
                        busy  <= 1'b0;
                        state <= READY;
                    end
                end
                READY: begin
                    if (!cs_q) begin
                        state   <= SHIFT;
                        shreg   <= frame;
                        miso    <= frame[31];
                        bit_cnt <= 5'd31;
                        drained <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cs_q) begin
                        miso     <= 1'b0;
                        state    <= CONVERT;
                        conv_cnt <= '0;
                        busy     <= 1'b1;
                    end else if (sclk_fall && !drained) begin
                        if (bit_cnt != 5'd0) begin
                            shreg   <= shreg << 1;
                            miso    <= shreg[30];
                            bit_cnt <= bit_cnt - 5'd1;
                        end else begin
                            miso       <= 1'b0;
                            frame_done <= 1'b1;
                            drained    <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
